// File: rtl/maria_pkg.sv
// maria_pkg: shared DMA scheduler state encoding and display-list constants.
package maria_pkg;
   typedef enum logic [2:0] {
      S_IDLE, S_FRAME_DLL, S_WAIT_HBS, S_LIST, S_NEXT_DLL, S_RELEASE
   } dma_state_t;
   localparam int DLL_ENTRY_BYTES = 3;
   localparam int ZONE_W = 4;
endpackage

// File: rtl/dma_zone_counter.sv
// dma_zone_counter: zone line counter, loaded from a DLL entry and counted down per line without wrapping.
module dma_zone_counter
   import maria_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              load,
   input  logic              dec,
   input  logic [ZONE_W-1:0] load_val,
   output logic [ZONE_W-1:0] zone_row,
   output logic              zero
);
   assign zero = zone_row == '0;
   always_ff @(posedge clk or posedge reset)
      if (reset) zone_row <= '0;
      else if (en) zone_row <= load ? load_val : (dec && !zero) ? zone_row - 1'b1 : zone_row;
endmodule

// File: rtl/dma_line_scheduler.sv
// dma_line_scheduler: per-line DMA sequencing of DLL fetches, display-list fetches and CPU halt.
module dma_line_scheduler
   import maria_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       mclk1,
   input  logic       vbe,
   input  logic       hbs,
   input  logic       lrc,
   input  logic       vblank,
   input  logic       dma_en,
   input  logic       dll_ack,
   input  logic       list_done,
   input  logic [3:0] dll_offset,
   input  logic [0:0] dll_dli,
   output logic       dll_req,
   output logic       list_req,
   output logic       halt,
   output logic       list_abort,
   output logic       lbuf_swap,
   output logic       nmi,
   output logic [3:0] zone_row
);
   dma_state_t state;
   logic zero;
   logic restart, dll_hit, line_end;
   // vbe outranks everything outside IDLE; IDLE only leaves when DMA is enabled
   assign restart  = vbe && (state != S_IDLE || dma_en);
   assign dll_hit  = dll_req && dll_ack && (state == S_FRAME_DLL || state == S_NEXT_DLL);
   assign line_end = state == S_LIST && list_req && (list_done || lrc);

   dma_zone_counter u_zone (
      .clk     (clk),
      .reset   (reset),
      .en      (mclk1),
      .load    (dll_hit && !restart),
      .dec     (line_end && !restart),
      .load_val(dll_offset),
      .zone_row(zone_row),
      .zero    (zero)
   );

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state      <= S_IDLE;
         halt       <= 1'b0;
         dll_req    <= 1'b0;
         list_req   <= 1'b0;
         list_abort <= 1'b0;
         lbuf_swap  <= 1'b0;
         nmi        <= 1'b0;
      end else begin
         list_abort <= 1'b0;
         lbuf_swap  <= 1'b0;
         nmi        <= 1'b0;
         if (mclk1) begin
            lbuf_swap <= lrc && state != S_IDLE;
            if (restart) begin
               state    <= S_FRAME_DLL;
               halt     <= 1'b0;
               list_req <= 1'b0;
               dll_req  <= 1'b0;
            end else begin
               case (state)
                  S_FRAME_DLL: if (dll_hit) begin
                     dll_req <= 1'b0;
                     state   <= S_WAIT_HBS;
                  end else dll_req <= 1'b1;
                  S_WAIT_HBS: if (hbs) begin
                     if (!vblank && dma_en) begin
                        halt     <= 1'b1;
                        list_req <= 1'b1;
                        state    <= S_LIST;
                     end else state <= S_IDLE;
                  end
                  // list_done wins over a coincident lrc, so only a true overrun aborts
                  S_LIST: if (line_end) begin
                     list_req   <= 1'b0;
                     list_abort <= !list_done;
                     state      <= zero ? S_NEXT_DLL : S_RELEASE;
                  end
                  S_NEXT_DLL: if (dll_hit) begin
                     dll_req <= 1'b0;
                     nmi     <= dll_dli[0];
                     state   <= S_RELEASE;
                  end else dll_req <= 1'b1;
                  S_RELEASE: begin
                     halt  <= 1'b0;
                     state <= S_WAIT_HBS;
                  end
                  default: state <= S_IDLE;
               endcase
            end
         end
      end
endmodule

// File: tb/tb_dma_line_scheduler.sv
// tb_dma_line_scheduler: directed scenarios with hand-computed outputs after each mclk1 tick.
module tb_dma_line_scheduler;
   logic clk = 1'b0, reset = 1'b1, mclk1 = 1'b0;
   logic vbe = 1'b0, hbs = 1'b0, lrc = 1'b0, vblank = 1'b1, dma_en = 1'b1;
   logic dll_ack = 1'b0, list_done = 1'b0;
   logic [3:0] dll_offset = 4'd0;
   logic [0:0] dll_dli = 1'b0;
   logic dll_req, list_req, halt, list_abort, lbuf_swap, nmi;
   logic [3:0] zone_row;
   int n_chk = 0, n_fail = 0;

   dma_line_scheduler dut (
      .clk(clk), .reset(reset), .mclk1(mclk1), .vbe(vbe), .hbs(hbs), .lrc(lrc),
      .vblank(vblank), .dma_en(dma_en), .dll_ack(dll_ack), .list_done(list_done),
      .dll_offset(dll_offset), .dll_dli(dll_dli), .dll_req(dll_req), .list_req(list_req),
      .halt(halt), .list_abort(list_abort), .lbuf_swap(lbuf_swap), .nmi(nmi), .zone_row(zone_row)
   );

   always #5 clk = ~clk;

   // one idle clk with mclk1 low, then one enabled clk carrying the strobes; sample 1 ns after the edge
   task automatic tick(input logic v, input logic h, input logic l, input logic a, input logic d);
      @(negedge clk);
      {mclk1, vbe, hbs, lrc, dll_ack, list_done} = '0;
      @(negedge clk);
      {mclk1, vbe, hbs, lrc, dll_ack, list_done} = {1'b1, v, h, l, a, d};
      @(posedge clk);
      #1;
   endtask

   // expected fields: halt, dll_req, list_req, list_abort, lbuf_swap, nmi, zone_row
   task automatic chk(input string tag, input logic hx, input logic dx, input logic lx,
                      input logic ax, input logic sx, input logic nx, input logic [3:0] zx);
      logic [9:0] obs, expv;
      obs  = {halt, dll_req, list_req, list_abort, lbuf_swap, nmi, zone_row};
      expv = {hx, dx, lx, ax, sx, nx, zx};
      n_chk++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed h/dr/lr/ab/sw/nmi/zr=%b required %b", tag, obs, expv);
      end
   endtask

   initial begin
      #2 chk("reset_state", 0, 0, 0, 0, 0, 0, 4'd0);
      @(negedge clk) reset = 1'b0;
      // normal zone of three lines
      tick(1, 0, 0, 0, 0); chk("vbe_to_frame", 0, 0, 0, 0, 0, 0, 4'd0);
      tick(0, 0, 0, 0, 0); chk("frame_dll_req", 0, 1, 0, 0, 0, 0, 4'd0);
      dll_offset = 4'd2; dll_dli = 1'b0; vblank = 1'b0;
      tick(0, 0, 0, 1, 0); chk("frame_ack_load", 0, 0, 0, 0, 0, 0, 4'd2);
      tick(0, 1, 0, 0, 0); chk("line1_halt", 1, 0, 1, 0, 0, 0, 4'd2);
      tick(0, 0, 0, 0, 1); chk("line1_done", 1, 0, 0, 0, 0, 0, 4'd1);
      tick(0, 0, 0, 0, 0); chk("line1_release", 0, 0, 0, 0, 0, 0, 4'd1);
      @(negedge clk) {mclk1, hbs} = 2'b01;
      @(posedge clk) #1 chk("hbs_gated", 0, 0, 0, 0, 0, 0, 4'd1);
      tick(0, 1, 0, 0, 0); chk("line2_halt", 1, 0, 1, 0, 0, 0, 4'd1);
      tick(0, 0, 0, 0, 1); chk("line2_done", 1, 0, 0, 0, 0, 0, 4'd0);
      tick(0, 0, 0, 0, 0); chk("line2_release", 0, 0, 0, 0, 0, 0, 4'd0);
      tick(0, 1, 0, 0, 0); chk("line3_halt", 1, 0, 1, 0, 0, 0, 4'd0);
      tick(0, 0, 0, 0, 1); chk("line3_done", 1, 0, 0, 0, 0, 0, 4'd0);
      tick(0, 0, 0, 0, 0); chk("next_dll_req", 1, 1, 0, 0, 0, 0, 4'd0);
      // DLI on the second entry
      dll_offset = 4'd1; dll_dli = 1'b1;
      tick(0, 0, 0, 1, 0); chk("dli_nmi", 1, 0, 0, 0, 0, 1, 4'd1);
      tick(0, 0, 0, 0, 0); chk("dli_release", 0, 0, 0, 0, 0, 0, 4'd1);
      dll_offset = 4'd5; dll_dli = 1'b0;
      tick(0, 0, 0, 1, 0); chk("stray_dll_ack", 0, 0, 0, 0, 0, 0, 4'd1);
      tick(0, 0, 0, 0, 1); chk("stray_list_done", 0, 0, 0, 0, 0, 0, 4'd1);
      // overrun: lrc before list_done
      tick(0, 1, 0, 0, 0); chk("ovr_halt", 1, 0, 1, 0, 0, 0, 4'd1);
      tick(0, 0, 1, 0, 0); chk("ovr_abort", 1, 0, 0, 1, 1, 0, 4'd0);
      tick(0, 0, 0, 0, 0); chk("ovr_release", 0, 0, 0, 0, 0, 0, 4'd0);
      // list_done and lrc together
      tick(0, 1, 0, 0, 0); chk("sim_halt", 1, 0, 1, 0, 0, 0, 4'd0);
      tick(0, 0, 1, 0, 1); chk("sim_no_abort", 1, 0, 0, 0, 1, 0, 4'd0);
      tick(0, 0, 0, 0, 0); chk("sim_next_req", 1, 1, 0, 0, 0, 0, 4'd0);
      dll_offset = 4'd3;
      tick(0, 0, 0, 1, 0); chk("sim_ack", 1, 0, 0, 0, 0, 0, 4'd3);
      tick(0, 0, 0, 0, 0); chk("sim_release", 0, 0, 0, 0, 0, 0, 4'd3);
      // DMA switched off mid-line
      tick(0, 1, 0, 0, 0); chk("off_halt", 1, 0, 1, 0, 0, 0, 4'd3);
      dma_en = 1'b0;
      tick(0, 0, 0, 0, 0); chk("off_line_held", 1, 0, 1, 0, 0, 0, 4'd3);
      tick(0, 0, 0, 0, 1); chk("off_line_done", 1, 0, 0, 0, 0, 0, 4'd2);
      tick(0, 0, 0, 0, 0); chk("off_release", 0, 0, 0, 0, 0, 0, 4'd2);
      tick(0, 1, 0, 0, 0); chk("off_to_idle", 0, 0, 0, 0, 0, 0, 4'd2);
      tick(0, 0, 1, 0, 0); chk("idle_no_swap", 0, 0, 0, 0, 0, 0, 4'd2);
      tick(1, 0, 0, 0, 0); tick(0, 0, 0, 0, 0); chk("idle_vbe_disabled", 0, 0, 0, 0, 0, 0, 4'd2);
      // reset during NEXT_DLL
      dma_en = 1'b1; dll_offset = 4'd0;
      tick(1, 0, 0, 0, 0); tick(0, 0, 0, 0, 0); tick(0, 0, 0, 1, 0);
      chk("rst_setup_load", 0, 0, 0, 0, 0, 0, 4'd0);
      tick(0, 1, 0, 0, 0); tick(0, 0, 0, 0, 1); tick(0, 0, 0, 0, 0);
      chk("rst_in_next_dll", 1, 1, 0, 0, 0, 0, 4'd0);
      @(negedge clk) reset = 1'b1;
      #1 chk("rst_async_clear", 0, 0, 0, 0, 0, 0, 4'd0);
      @(negedge clk) reset = 1'b0;
      tick(1, 0, 0, 0, 0); tick(0, 0, 0, 0, 0); chk("rst_restart_req", 0, 1, 0, 0, 0, 0, 4'd0);
      // vbe mid-line restarts the frame
      dll_offset = 4'd1;
      tick(0, 0, 0, 1, 0); tick(0, 1, 0, 0, 0); chk("vbe_mid_setup", 1, 0, 1, 0, 0, 0, 4'd1);
      tick(1, 0, 0, 0, 0); chk("vbe_mid_clear", 0, 0, 0, 0, 0, 0, 4'd1);
      tick(0, 0, 0, 0, 0); chk("vbe_mid_frame_req", 0, 1, 0, 0, 0, 0, 4'd1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
